// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 link types, error codes and command bytes
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;

    // The PS/2 frame parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte request handshake
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchronizers for kb_clk/kb_data plus clock fall detect
module ps2_line_sync (
    input  logic clk,
    input  logic resetn,
    input  logic kb_clk_in,
    input  logic kb_data_in,
    output logic sync_clk,
    output logic sync_data,
    output logic clk_fall
);
    logic [1:0] clk_sr;
    logic [1:0] data_sr;
    logic       clk_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sr   <= 2'b11;
            data_sr  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[0], kb_clk_in};
            data_sr  <= {data_sr[0], kb_data_in};
            clk_prev <= clk_sr[1];
        end
    end

    assign sync_clk  = clk_sr[1];
    assign sync_data = data_sr[1];
    assign clk_fall  = clk_prev & ~clk_sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; PS2_TX_RETRY_EN enables resends
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                clk,
    input  logic                resetn,
    ps2_host_tx_if.slave        tx,
    input  logic                kb_clk_in,
    input  logic                kb_data_in,
    output logic                kb_clk_oe,
    output logic                kb_data_oe,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int RT_W  = $clog2(MAX_RETRY + 2);

    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0]  RETRY_MAX = RT_W'(MAX_RETRY);

    ps2_state_t       state, state_n;
    logic [7:0]       data_q, data_n;
    logic             parity_q, parity_n;
    logic [3:0]       fall_cnt, fall_cnt_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic [TO_W-1:0]  to_cnt, to_cnt_n;
    logic [RT_W-1:0]  retry_cnt, retry_n;
    logic             data_oe_q, data_oe_n;
    logic             done_q, done_n;
    logic             err_q, err_n;
    logic [1:0]       err_code_q, err_code_n;

    logic             sync_clk;
    logic             sync_data;
    logic             clk_fall;
    logic             timeout;
    logic             fail;
    logic [1:0]       fail_code;

    ps2_line_sync u_sync (
        .clk        (clk),
        .resetn     (resetn),
        .kb_clk_in  (kb_clk_in),
        .kb_data_in (kb_data_in),
        .sync_clk   (sync_clk),
        .sync_data  (sync_data),
        .clk_fall   (clk_fall)
    );

    // State and datapath registers; reset releases both lines on the next edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            fall_cnt   <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            retry_cnt  <= '0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state      <= state_n;
            data_q     <= data_n;
            parity_q   <= parity_n;
            fall_cnt   <= fall_cnt_n;
            inh_cnt    <= inh_cnt_n;
            to_cnt     <= to_cnt_n;
            retry_cnt  <= retry_n;
            data_oe_q  <= data_oe_n;
            done_q     <= done_n;
            err_q      <= err_n;
            err_code_q <= err_code_n;
        end
    end

    // Next-state logic: inhibit, then shift start/data/parity/stop on device clock falls, then ACK.
    always_comb begin
        state_n    = state;
        data_n     = data_q;
        parity_n   = parity_q;
        fall_cnt_n = fall_cnt;
        inh_cnt_n  = inh_cnt;
        to_cnt_n   = to_cnt;
        retry_n    = retry_cnt;
        data_oe_n  = data_oe_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        err_code_n = err_code_q;
        fail       = 1'b0;
        fail_code  = ERR_NONE;
        timeout    = (to_cnt == TO_LAST) && !clk_fall;

        case (state)
            IDLE: begin
                if (tx.tx_valid) begin
                    data_n     = tx.tx_data;
                    parity_n   = odd_parity(tx.tx_data);
                    fall_cnt_n = '0;
                    inh_cnt_n  = '0;
                    to_cnt_n   = '0;
                    retry_n    = '0;
                    data_oe_n  = 1'b0;
                    err_code_n = ERR_NONE;
                    state_n    = INHIBIT;
                end
            end

            INHIBIT: begin
                // Device clock activity here is ignored; we own the clock line.
                if (inh_cnt == INH_LAST) begin
                    data_oe_n = 1'b1;
                    to_cnt_n  = '0;
                    state_n   = REQ;
                end else begin
                    inh_cnt_n = inh_cnt + 1'b1;
                end
            end

            REQ, XFER: begin
                to_cnt_n = clk_fall ? '0 : to_cnt + 1'b1;
                if (clk_fall) begin
                    fall_cnt_n = fall_cnt + 1'b1;
                    if (fall_cnt < 4'd8) begin
                        data_oe_n = ~data_q[fall_cnt[2:0]];
                    end else if (fall_cnt == 4'd8) begin
                        data_oe_n = ~parity_q;
                    end else begin
                        data_oe_n = 1'b0;
                    end
                    state_n = (fall_cnt == 4'd9) ? ACK : XFER;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end

            ACK: begin
                to_cnt_n = clk_fall ? '0 : to_cnt + 1'b1;
                if (clk_fall) begin
                    if (!sync_data) begin
                        state_n = WAIT_IDLE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NACK;
                    end
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end

            WAIT_IDLE: begin
                to_cnt_n = clk_fall ? '0 : to_cnt + 1'b1;
                if (sync_clk && sync_data) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // A failed attempt either restarts the frame with the latched byte or ends the transfer.
        if (fail) begin
            data_oe_n  = 1'b0;
            fall_cnt_n = '0;
            inh_cnt_n  = '0;
            to_cnt_n   = '0;
            if (RETRY_EN && (retry_cnt < RETRY_MAX)) begin
                retry_n = retry_cnt + 1'b1;
                state_n = INHIBIT;
            end else begin
                err_n      = 1'b1;
                err_code_n = fail_code;
                state_n    = IDLE;
            end
        end
    end

    assign kb_clk_oe   = (state == INHIBIT);
    assign kb_data_oe  = data_oe_q | ((state == INHIBIT) && (inh_cnt == INH_LAST));
    assign tx.tx_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 2500;
    localparam int TO  = 5000;
    localparam int MR  = 2;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS   = MR + 1;
    localparam int TO_EXPECT  = TO + MR * (INH + TO);
`else
    localparam int ATTEMPTS   = 1;
    localparam int TO_EXPECT  = TO;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       kb_clk_in, kb_data_in;
    logic       kb_clk_oe, kb_data_oe;
    logic       busy, done, err;
    logic [1:0] err_code;

    ps2_host_tx_if tx_if();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .tx         (tx_if),
        .kb_clk_in  (kb_clk_in),
        .kb_data_in (kb_data_in),
        .kb_clk_oe  (kb_clk_oe),
        .kb_data_oe (kb_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #20 clk = ~clk;

    assign kb_clk_in  = dev_clk & ~kb_clk_oe;
    assign kb_data_in = dev_data & ~kb_data_oe;

    int inh_total  = 0;
    int done_total = 0;
    int err_total  = 0;
    int both_total = 0;

    always @(negedge clk) begin
        if (kb_clk_oe) inh_total <= inh_total + 1;
        if (done)      done_total <= done_total + 1;
        if (err)       err_total <= err_total + 1;
        if (done && err) both_total <= both_total + 1;
    end

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
        bit          exp_done;
        logic [1:0]  exp_code;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   base_done, base_err, base_inh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Frame as the device sees it: bit0 start, bits 1..8 data LSB first, bit9 parity, bit10 stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            if (d[i]) ones++;
        end
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] d, input bit exp_done, input logic [1:0] code);
        exp_t e;
        for (int n = 0; n < 1000 && tx_if.tx_ready !== 1'b1; n++) @(negedge clk);
        chk("ready_before_send", tx_if.tx_ready, 1);
        e.data = d;
        e.frame = frame_of(d);
        e.exp_done = exp_done;
        e.exp_code = code;
        sb.push_back(e);
        base_done = done_total;
        base_err  = err_total;
        base_inh  = inh_total;
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
    endtask

    // Device: waits for the host request, clocks 11 falls, samples at each rising edge, answers ACK.
    task automatic device(input int half, input bit ack, input int stop_at,
                          output logic [10:0] bits, output bit ok);
        ok = 1'b0;
        bits = '0;
        for (int n = 0; n < 20000 && !(kb_clk_oe == 1'b0 && kb_data_oe == 1'b1); n++) @(negedge clk);
        if (!(kb_clk_oe == 1'b0 && kb_data_oe == 1'b1)) return;
        ok = 1'b1;
        wait_cycles(20);
        bits[0] = kb_data_in;
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == stop_at) begin
                wait_cycles(10);
                return;
            end
            wait_cycles(half);
            dev_clk = 1'b1;
            if (i <= 10) bits[i] = kb_data_in;
            if (i == 10) dev_data = ack;
            if (i < 11) wait_cycles(half);
            else dev_data = 1'b1;
        end
    endtask

    task automatic check_outcome(input logic [10:0] frame, input bit check_frame, input int attempts);
        exp_t e;
        for (int n = 0; n < 20000 && (done_total + err_total) == (base_done + base_err); n++)
            @(negedge clk);
        chk("outcome_seen", ((done_total + err_total) != (base_done + base_err)) ? 1 : 0, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (check_frame) chk($sformatf("frame_%02h", e.data), frame, e.frame);
        chk("done_pulses", done_total - base_done, e.exp_done ? 1 : 0);
        chk("err_pulses", err_total - base_err, e.exp_done ? 0 : 1);
        chk("err_code", err_code, e.exp_code);
        chk("inhibit_cycles", inh_total - base_inh, INH * attempts);
        @(negedge clk);
        chk("ready_after", tx_if.tx_ready, 1);
        chk("clk_oe_after", kb_clk_oe, 0);
        chk("data_oe_after", kb_data_oe, 0);
    endtask

    initial begin
        logic [10:0] bits;
        bit ok;
        int n;

        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        wait_cycles(5);
        chk("rst_tx_ready", tx_if.tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clk_oe", kb_clk_oe, 0);
        chk("rst_data_oe", kb_data_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, ERR_NONE);
        resetn = 1'b1;
        wait_cycles(5);

        // Set-LED command at 12.5 kHz device clock.
        send(PS2_CMD_SET_LED, 1'b1, ERR_NONE);
        device(1000, 1'b0, 0, bits, ok);
        chk("dev_req_ed", ok, 1);
        chk("ed_frame_literal", bits, 11'b11111011010);
        check_outcome(bits, 1'b1, 1);

        // Parity corners.
        send(8'h01, 1'b1, ERR_NONE);
        device(50, 1'b0, 0, bits, ok);
        chk("parity_01", bits[9], 0);
        check_outcome(bits, 1'b1, 1);

        send(PS2_CMD_RESET, 1'b1, ERR_NONE);
        device(50, 1'b0, 0, bits, ok);
        chk("parity_ff", bits[9], 1);
        check_outcome(bits, 1'b1, 1);

        // Device refuses: ACK bit high.
        send(8'hA7, 1'b0, ERR_NACK);
        for (int a = 0; a < ATTEMPTS; a++) begin
            device(50, 1'b1, 0, bits, ok);
            chk("dev_req_nack", ok, 1);
        end
        check_outcome(bits, 1'b1, ATTEMPTS);

        // Device never clocks: timeout measured from the first request cycle.
        send(PS2_CMD_RESET, 1'b0, ERR_TIMEOUT);
        for (n = 0; n < 5000 && !(kb_clk_oe == 1'b0 && kb_data_oe == 1'b1); n++) @(negedge clk);
        n = 0;
        while (err !== 1'b1 && n < TO_EXPECT + 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, TO_EXPECT);
        chk("timeout_data_oe", kb_data_oe, 0);
        check_outcome(bits, 1'b0, ATTEMPTS);

        // Reset in the middle of a frame.
        send(8'h3C, 1'b0, ERR_NONE);
        device(50, 1'b0, 5, bits, ok);
        chk("dev_req_abort", ok, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_clk_oe", kb_clk_oe, 0);
        chk("abort_data_oe", kb_data_oe, 0);
        chk("abort_ready", tx_if.tx_ready, 1);
        resetn = 1'b1;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        wait_cycles(50);
        chk("abort_no_done", done_total - base_done, 0);
        chk("abort_no_err", err_total - base_err, 0);
        void'(sb.pop_front());

        send(PS2_CMD_ENABLE, 1'b1, ERR_NONE);
        device(50, 1'b0, 0, bits, ok);
        check_outcome(bits, 1'b1, 1);

        // A second request held during a transfer is ignored.
        send(8'h5A, 1'b1, ERR_NONE);
        tx_if.tx_data  = 8'hA5;
        tx_if.tx_valid = 1'b1;
        device(50, 1'b0, 0, bits, ok);
        chk("held_ready_low", tx_if.tx_ready, 0);
        tx_if.tx_valid = 1'b0;
        check_outcome(bits, 1'b1, 1);
        wait_cycles(10);
        chk("held_not_accepted", busy, 0);

        chk("done_err_overlap", both_total, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
